// File: rtl/ffe_equalizer.sv
// ---------------------------------------------------------------------------
// ffe_equalizer
//
// Feed-forward equalizer (TAPS-tap signed FIR) for the SerDes receive path.
// It sits between the channel model and the slicer. Coefficients can be
// rewritten at run time. The datapath is a short pipeline:
//   capture edge E   : delay line shifts in the sample, v1 set
//   edge E+1         : per-tap products registered, v2 set
//   edge E+2         : sum, arithmetic shift, narrowing; out_valid set
//
// Optional feature, selected at compile time:
//   FFE_SATURATE_EN  defined   -> output clips to the OUT_W range, and
//                                 sat_flag marks the clipped samples
//                    undefined -> output wraps (low OUT_W bits kept), and
//                                 sat_flag is constant 0
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset; overrides everything
//   in_valid    in   in_data carries a sample this cycle
//   in_data     in   signed sample, DATA_W bits
//   flush       in   clears delay line and pipeline valids, keeps coefficients
//   coef_we     in   coefficient write strobe
//   coef_addr   in   tap index; indices >= TAPS are ignored
//   coef_wdata  in   signed coefficient, COEF_W bits
//   out_valid   out  out_data holds a new equalized sample this cycle
//   out_data    out  signed equalized sample, OUT_W bits; holds when idle
//   sat_flag    out  out_data was clipped (meaningful with out_valid only)
// ---------------------------------------------------------------------------
module ffe_equalizer #(
  parameter int DATA_W     = 8,
  parameter int COEF_W     = 8,
  parameter int TAPS       = 5,
  parameter int FRAC_SHIFT = 6,
  parameter int OUT_W      = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     flush,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     sat_flag
);

  localparam int PROD_W = DATA_W + COEF_W;
  // The extra $clog2(TAPS) bits cover the growth of summing TAPS products.
  localparam int ACC_W  = PROD_W + $clog2(TAPS);

  localparam logic signed [COEF_W-1:0] COEF_UNITY = COEF_W'(1 << FRAC_SHIFT);

  // -------------------------------------------------------------------------
  // Coefficient file
  // -------------------------------------------------------------------------
  logic signed [COEF_W-1:0] r_coef [TAPS];

  // NOTE: this small register file is reset on purpose: the reset contents
  // (unity on tap 0) make the block a pass-through until software programs it.
  // Large RAM-style memories would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        r_coef[k] <= (k == 0) ? COEF_UNITY : '0;
      end
    end else if (coef_we && (int'(coef_addr) < TAPS)) begin
      r_coef[coef_addr] <= coef_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: delay line. Bubbles do not shift it; flush zeroes it.
  // -------------------------------------------------------------------------
  logic signed [DATA_W-1:0] r_d [TAPS];
  logic                     r_v1;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < TAPS; k++) begin
        r_d[k] <= '0;
      end
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_d[0] <= in_data;
        for (int k = 1; k < TAPS; k++) begin
          r_d[k] <= r_d[k-1];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: registered products. Coefficients are sampled here, so a write
  // landing on the capture edge of a sample already applies to that sample.
  // Products are recomputed every cycle; v2 says whether they matter.
  // -------------------------------------------------------------------------
  logic signed [PROD_W-1:0] r_prod [TAPS];
  logic                     r_v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        r_prod[k] <= '0;
      end
      r_v2 <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        r_prod[k] <= PROD_W'(r_d[k]) * PROD_W'(r_coef[k]);
      end
      r_v2 <= flush ? 1'b0 : r_v1;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3 combinational part: sum, shift and narrow
  // -------------------------------------------------------------------------
  logic signed [ACC_W-1:0] w_acc;
  logic signed [OUT_W-1:0] w_out;
  logic                    w_sat;

  // NOTE: blocking assignments are correct inside always_comb; the running
  // sum must see its own update on each loop iteration. The default written
  // first also keeps the block free of inferred latches.
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_acc = w_acc + ACC_W'(r_prod[k]);
    end
  end

`ifdef FFE_SATURATE_EN
  // One guard bit above both the accumulator and output widths lets a
  // plain signed compare decide whether the value fits in OUT_W bits.
  localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [EXT_W-1:0] OUT_MAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] w_ext;
  logic                    w_hi;
  logic                    w_lo;

  // >>> on a signed operand is arithmetic: it floors toward minus infinity.
  assign w_ext = EXT_W'(w_acc >>> FRAC_SHIFT);
  assign w_hi  = (w_ext > OUT_MAX);
  assign w_lo  = (w_ext < OUT_MIN);
  assign w_sat = w_hi | w_lo;
  assign w_out = w_hi ? OUT_MAX[OUT_W-1:0] :
                 w_lo ? OUT_MIN[OUT_W-1:0] :
                        w_ext[OUT_W-1:0];
`else
  // Wrapping keeps the low OUT_W bits of the shifted sum.
  assign w_out = OUT_W'(w_acc >>> FRAC_SHIFT);
  assign w_sat = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Stage 3 registers: data and flag only move with a valid result.
  // -------------------------------------------------------------------------
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_sat_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat_flag  <= 1'b0;
    end else begin
      r_out_valid <= flush ? 1'b0 : r_v2;
      if (r_v2 && !flush) begin
        r_out_data <= w_out;
        r_sat_flag <= w_sat;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sat_flag  = r_sat_flag;

endmodule
